// File: rtl/verificador_paridade_par.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : verificador_paridade_par
// Purpose  : Receive end of the serial even-parity link. Deframes a serial
//            stream (start bit, DATA_W data bits LSB first, even-parity bit,
//            stop bit), checks parity and the stop bit, and presents the
//            parallel word with error flags plus a saturating bad-frame count.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-low reset (0 = reset)
//            in_bit     - serial line bit
//            in_valid   - in_bit is sampled only when this is 1
//            data_out   - last received word, held until the next frame ends
//            data_valid - one-cycle pulse: frame ended, outputs updated
//            parity_err - last frame failed the even-parity check (held)
//            frame_err  - last frame had a 0 stop bit (held)
//            err_count  - saturating count of frames with any error
//            busy       - 1 whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module verificador_paridade_par #(
   parameter int DATA_W    = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_bit,
   input  logic                 in_valid,
   output logic [DATA_W-1:0]    data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 busy
);

   // Bit counter only has to address data bit positions 0..DATA_W-1.
   localparam int                 c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);
   localparam logic               c_PAR   = 1'b0;   // even ones seen so far
   localparam logic               c_IMPAR = 1'b1;   // odd ones seen so far

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DATA   = 2'b01,
      PARITY = 2'b10,
      STOP   = 2'b11
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [DATA_W-1:0]    r_shift;
   logic                 r_parity;
   logic                 r_perr;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic: the FSM only advances on cycles carrying a line bit.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      if (in_valid) begin
         unique case (r_state)
            IDLE:    w_next_state = in_bit ? IDLE : DATA;
            DATA:    w_next_state = (r_cnt == c_LAST) ? PARITY : DATA;
            PARITY:  w_next_state = STOP;
            STOP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   assign busy = (r_state != IDLE);

   // ------------------------------------------------------------------------
   // Datapath: shift register, running parity, result registers, counter.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_shift    <= '0;
         r_parity   <= c_PAR;
         r_perr     <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         err_count  <= '0;
      end else begin
         data_valid <= 1'b0;
         if (in_valid) begin
            case (r_state)
               IDLE: begin
                  if (!in_bit) begin
                     r_cnt    <= '0;
                     r_parity <= c_PAR;
                  end
               end
               DATA: begin
                  r_shift[r_cnt] <= in_bit;
                  if (in_bit) begin
                     r_parity <= ~r_parity;
                  end
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
               PARITY: begin
                  // Total ones including the parity bit must be even.
                  r_perr <= (r_parity == c_IMPAR) ^ in_bit;
               end
               STOP: begin
                  // Bad frames are still delivered, just flagged.
                  data_out   <= r_shift;
                  parity_err <= r_perr;
                  frame_err  <= ~in_bit;
                  data_valid <= 1'b1;
                  if ((r_perr || !in_bit) && (err_count != {ERR_CNT_W{1'b1}})) begin
                     err_count <= err_count + ERR_CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_verificador_paridade_par.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_verificador_paridade_par
// Purpose  : Scoreboard bench for verificador_paridade_par. Two instances
//            share one serial stream: one with an 8-bit error counter and one
//            with a 2-bit counter so saturation can be observed. Expected
//            frame results are queued when a frame is sent and checked by a
//            monitor whenever data_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_verificador_paridade_par;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_bit;
   logic       in_valid;

   logic [7:0] dout_a, dout_b;
   logic       dv_a, dv_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   always #5 clk = ~clk;

   verificador_paridade_par #(.DATA_W(8), .ERR_CNT_W(8)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .in_bit     (in_bit),
      .in_valid   (in_valid),
      .data_out   (dout_a),
      .data_valid (dv_a),
      .parity_err (perr_a),
      .frame_err  (ferr_a),
      .err_count  (cnt_a),
      .busy       (busy_a)
   );

   verificador_paridade_par #(.DATA_W(8), .ERR_CNT_W(2)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .in_bit     (in_bit),
      .in_valid   (in_valid),
      .data_out   (dout_b),
      .data_valid (dv_b),
      .parity_err (perr_b),
      .frame_err  (ferr_b),
      .err_count  (cnt_b),
      .busy       (busy_b)
   );

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic [7:0] cnt_a;
      logic [1:0] cnt_b;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] m_cnt_a  = 8'd0;
   logic [1:0] m_cnt_b  = 2'd0;
   int         gap_seq  = 0;
   logic       prev_dv  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One serial bit, optionally preceded by idle (in_valid=0) cycles that
   // carry the inverted bit to prove the line is ignored while not valid.
   task automatic send_bit(input logic b, input int gap, input logic exp_busy);
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_bit   = ~b;
         @(posedge clk);
         #1;
         chk("busy_in_gap_a", busy_a, exp_busy);
         chk("busy_in_gap_b", busy_b, exp_busy);
      end
      in_valid = 1'b1;
      in_bit   = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic int next_gap(input logic use_gaps);
      if (!use_gaps) return 0;
      gap_seq++;
      return 1 + (gap_seq % 3);
   endfunction

   task automatic send_frame(input logic [7:0] w, input logic par,
                             input logic stop, input logic use_gaps);
      exp_t e;
      int   ones;
      ones   = $countones(w) + int'(par);
      e.data = w;
      e.perr = (ones % 2) != 0;
      e.ferr = !stop;
      if (e.perr || e.ferr) begin
         if (m_cnt_a != 8'hFF) m_cnt_a = m_cnt_a + 8'd1;
         if (m_cnt_b != 2'h3)  m_cnt_b = m_cnt_b + 2'd1;
      end
      e.cnt_a = m_cnt_a;
      e.cnt_b = m_cnt_b;
      sb_q.push_back(e);
      send_bit(1'b0, next_gap(use_gaps), 1'b0);
      for (int i = 0; i < 8; i++) send_bit(w[i], next_gap(use_gaps), 1'b1);
      send_bit(par,  next_gap(use_gaps), 1'b1);
      send_bit(stop, next_gap(use_gaps), 1'b1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dout_a"}, dout_a, 0);
      chk({tag, "_dout_b"}, dout_b, 0);
      chk({tag, "_dv_a"},   dv_a,   0);
      chk({tag, "_perr_a"}, perr_a, 0);
      chk({tag, "_ferr_a"}, ferr_a, 0);
      chk({tag, "_cnt_a"},  cnt_a,  0);
      chk({tag, "_cnt_b"},  cnt_b,  0);
      chk({tag, "_busy_a"}, busy_a, 0);
   endtask

   // Monitor: compares every delivered frame against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (dv_a !== dv_b) begin
         chk("dv_a_vs_dv_b", dv_a, dv_b);
      end
      if (dv_a === 1'b1) begin
         if (prev_dv) chk("dv_one_cycle", 1, 0);
         if (sb_q.size() == 0) begin
            chk("unexpected_data_valid", 1, 0);
         end else begin
            e = sb_q.pop_front();
            chk("data_out_a",   dout_a, e.data);
            chk("data_out_b",   dout_b, e.data);
            chk("parity_err_a", perr_a, e.perr);
            chk("parity_err_b", perr_b, e.perr);
            chk("frame_err_a",  ferr_a, e.ferr);
            chk("frame_err_b",  ferr_b, e.ferr);
            chk("err_count_a",  cnt_a,  e.cnt_a);
            chk("err_count_b",  cnt_b,  e.cnt_b);
            chk("busy_after_stop", busy_a, 0);
         end
      end
      prev_dv = (dv_a === 1'b1);
   end

   initial begin
      reset    = 1'b0;
      in_bit   = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b1;

      // Idle line: ones must not start a frame.
      for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 1'b0);
      chk("idle_busy", busy_a, 0);

      // Test 1: good frame 0xA5.
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      // Test 2: 0x07 bad parity, then good parity (back to back).
      send_frame(8'h07, 1'b0, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      // Test 3: framing error only.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      // Both errors at once: counter steps once.
      send_frame(8'h01, 1'b0, 1'b0, 1'b0);
      // Test 4: 0xA5 with 1-3 cycle in_valid gaps between bits.
      send_bit(1'b1, 0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // Test 5: reset after 4 data bits of 0x5A, then a full 0x5A frame.
      send_bit(1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0 ^ (i == 1 || i == 3), 0, 1'b1);
      chk("busy_mid_frame", busy_a, 1);
      reset = 1'b0;
      #2;
      chk_all_zero("midreset");
      @(posedge clk);
      #1;
      reset   = 1'b1;
      m_cnt_a = 8'd0;
      m_cnt_b = 2'd0;
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);

      // Test 6: five parity-bad frames saturate the 2-bit counter, then good.
      for (int i = 0; i < 5; i++) send_frame(8'h01, 1'b0, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b1, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb_q.size(), 0);
      chk("final_busy", busy_a, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
